// File: rtl/fifo_router_packetizer_pkg.sv
// Shared flit types and header field layout for the DLA->NoC packetizer.
// Offsets are measured down from the MSB of the FIFO word.
package fifo_router_packetizer_pkg;

  localparam int VC_NUM         = 2;
  localparam int FLIT_DATA_SIZE = 32;
  localparam int VC_ID_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  localparam int X_OFS   = 1;
  localparam int Y_OFS   = 5;
  localparam int L_OFS   = 9;
  localparam int LEN_OFS = 12;

  typedef enum logic [1:0] {
    HEADTAIL = 2'd0,
    HEAD     = 2'd1,
    BODY     = 2'd2,
    TAIL     = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_ID_W-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

endpackage

// File: rtl/fifo_router_packetizer_if.sv
// FIFO read side, router local port and status bundle of the packetizer.
// master = packetizer, slave = FIFO/router environment.
interface fifo_router_packetizer_if #(
  parameter int VC_NUM         = fifo_router_packetizer_pkg::VC_NUM,
  parameter int FLIT_DATA_SIZE = fifo_router_packetizer_pkg::FLIT_DATA_SIZE
);
  import fifo_router_packetizer_pkg::*;

  logic                      router_rdbuf_rempty;
  logic                      router_rdbuf_ren;
  logic [FLIT_DATA_SIZE-1:0] router_rdbuf_rdata;
  flit_t                     router_data_in;
  logic                      router_valid_in;
  logic [VC_NUM-1:0]         router_is_on_off_out;
  logic [VC_NUM-1:0]         router_is_allocatable_out;
  logic [15:0]               pkt_sent_cnt;
  logic                      len_err;

  modport master (
    input  router_rdbuf_rempty,
    input  router_rdbuf_rdata,
    input  router_is_on_off_out,
    input  router_is_allocatable_out,
    output router_rdbuf_ren,
    output router_data_in,
    output router_valid_in,
    output pkt_sent_cnt,
    output len_err
  );

  modport slave (
    output router_rdbuf_rempty,
    output router_rdbuf_rdata,
    output router_is_on_off_out,
    output router_is_allocatable_out,
    input  router_rdbuf_ren,
    input  router_data_in,
    input  router_valid_in,
    input  pkt_sent_cnt,
    input  len_err
  );

endinterface

// File: rtl/fifo_router_packetizer_rr_vc_select.sv
// Round-robin picker: first eligible VC at or after ptr_i, wrapping.
// Purely combinational; the owner holds the pointer.
module rr_vc_select #(
  parameter int VC_NUM = 2,
  parameter int VC_W   = 1
) (
  input  logic [VC_NUM-1:0] eligible_i,
  input  logic [VC_W-1:0]   ptr_i,
  output logic              any_o,
  output logic [VC_W-1:0]   sel_o
);

  int idx;

  always_comb begin
    any_o = 1'b0;
    sel_o = '0;
    idx   = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(ptr_i) + i) % VC_NUM;
      if (!any_o && eligible_i[idx]) begin
        any_o = 1'b1;
        sel_o = VC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_router_packetizer.sv
// Pops header/payload words from a 1-cycle FIFO and injects HEAD/BODY/TAIL
// flits into the router local port on a round-robin chosen, packet-held VC.
module fifo_router_packetizer #(
  parameter int VC_NUM         = fifo_router_packetizer_pkg::VC_NUM,
  parameter int FLIT_DATA_SIZE = fifo_router_packetizer_pkg::FLIT_DATA_SIZE,
  parameter int LEN_W          = 8,
  parameter int MAX_LEN        = 255
) (
  input logic                      clk_router,
  input logic                      rst_router_n,
  fifo_router_packetizer_if.master bus
);
  import fifo_router_packetizer_pkg::*;

  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HEAD,
    S_BODY
  } state_t;

  state_t            state_q, state_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [VC_W-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  out_q, out_d;
  flit_t             flit_q, flit_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              ren;
  logic              done;
  logic              vc_on;
  logic              any_elig;
  logic [VC_W-1:0]   pick;
  logic [VC_NUM-1:0] elig;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_single;
  logic              rempty;
  logic [FLIT_DATA_SIZE-1:0] rdata;

  assign rempty     = bus.router_rdbuf_rempty;
  assign rdata      = bus.router_rdbuf_rdata;
  assign elig       = bus.router_is_on_off_out
                    & bus.router_is_allocatable_out;
  assign vc_on      = bus.router_is_on_off_out[vc_q];
  assign hdr_len    = rdata[FLIT_DATA_SIZE-LEN_OFS -: LEN_W];
  assign hdr_single = rdata[0];

  rr_vc_select #(
    .VC_NUM (VC_NUM),
    .VC_W   (VC_W)
  ) u_rr (
    .eligible_i (elig),
    .ptr_i      (rr_q),
    .any_o      (any_elig),
    .sel_o      (pick)
  );

  always_comb begin
    state_d = state_q;
    vc_d    = vc_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    out_d   = out_q;
    flit_d  = flit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ren     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        out_d = '0;
        // valid_q here means a TAIL is on the wire: idle one cycle
        if (!rempty && any_elig && !valid_q) begin
          ren     = 1'b1;
          vc_d    = pick;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        valid_d      = 1'b1;
        flit_d.data  = rdata;
        flit_d.vc_id = VC_ID_W'(vc_q);
        if (hdr_single || hdr_len == '0) begin
          flit_d.flit_label = HEADTAIL;
          err_d             = !hdr_single;
          done              = 1'b1;
        end else begin
          flit_d.flit_label = HEAD;
          err_d             = int'(hdr_len) > MAX_LEN;
          rem_d             = hdr_len;
          ren               = !rempty && vc_on;
          out_d             = LEN_W'(ren);
          state_d           = S_HEAD;
        end
      end
      S_HEAD, S_BODY: begin
        state_d = S_BODY;
        if (out_q != '0) begin
          valid_d           = 1'b1;
          flit_d.data       = rdata;
          flit_d.flit_label = (rem_q == LEN_W'(1)) ? TAIL : BODY;
          rem_d             = rem_q - LEN_W'(1);
        end
        if (out_q != '0 && rem_q == LEN_W'(1)) begin
          done = 1'b1;
        end else begin
          ren   = !rempty && vc_on && (out_q < rem_q);
          out_d = LEN_W'(ren);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q + 16'd1;
      rr_d    = (vc_q == VC_W'(VC_NUM - 1)) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_router) begin
    if (!rst_router_n) begin
      state_q <= S_IDLE;
      vc_q    <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // the FIFO shares this reset, so never pop while it is held
  assign bus.router_rdbuf_ren = ren && rst_router_n;
  assign bus.router_data_in   = flit_q;
  assign bus.router_valid_in  = valid_q;
  assign bus.pkt_sent_cnt     = cnt_q;
  assign bus.len_err          = err_q;

endmodule

// File: tb/tb_fifo_router_packetizer.sv
// Bench for fifo_router_packetizer: FIFO model, flit scoreboard,
// vector table plus stall, bubble, round-robin and reset sequences.
module tb_fifo_router_packetizer;
  import fifo_router_packetizer_pkg::*;

  localparam int TB_MAX_LEN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_router_packetizer_if bus ();

  fifo_router_packetizer #(
    .LEN_W   (8),
    .MAX_LEN (TB_MAX_LEN)
  ) dut (
    .clk_router   (clk),
    .rst_router_n (rst_n),
    .bus          (bus)
  );

  logic [FLIT_DATA_SIZE-1:0] mem [0:511];
  int wr_n = 0;
  int rd_n = 0;
  logic hold_empty = 1'b0;
  logic [FLIT_DATA_SIZE-1:0] rdata_q = '0;
  logic [1:0] on_off = 2'b00;
  logic [1:0] alloc = 2'b00;

  assign bus.router_rdbuf_rempty       = hold_empty || (wr_n == rd_n);
  assign bus.router_rdbuf_rdata        = rdata_q;
  assign bus.router_is_on_off_out      = on_off;
  assign bus.router_is_allocatable_out = alloc;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_n    <= wr_n;
      rdata_q <= '0;
    end else if (bus.router_rdbuf_ren && rd_n < wr_n) begin
      rdata_q <= mem[rd_n];
      rd_n    <= rd_n + 1;
    end
  end

  flit_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops, nflits, first_ren, first_val, last_val;
  int err_cycles, bodies;
  int exp_cnt = 0;

  typedef struct {
    bit         single;
    int         len;
    logic [1:0] on_off;
    logic [1:0] alloc;
    int         vc;
    int         err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    pops = 0; nflits = 0; first_ren = -1; first_val = -1;
    last_val = -1; err_cycles = 0; bodies = 0;
  endtask

  // sample at negedge, then return just after the next posedge
  task automatic step();
    flit_t e;
    @(negedge clk);
    cyc++;
    if (bus.router_rdbuf_ren === 1'b1) begin
      pops++;
      if (first_ren < 0) first_ren = cyc;
      chk("pop_when_empty", 64'(bus.router_rdbuf_rempty), 64'(0));
    end
    if (bus.len_err === 1'b1) err_cycles++;
    if (bus.router_valid_in === 1'b1) begin
      nflits++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
      if (bus.router_data_in.flit_label == BODY) bodies++;
      if (bus.router_data_in.flit_label == TAIL ||
          bus.router_data_in.flit_label == HEADTAIL)
        chk("fetch_in_tail_cycle", 64'(bus.router_rdbuf_ren), 64'(0));
      chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("flit_label", 64'(bus.router_data_in.flit_label),
            64'(e.flit_label));
        chk("flit_vc", 64'(bus.router_data_in.vc_id), 64'(e.vc_id));
        chk("flit_data", 64'(bus.router_data_in.data), 64'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input bit single, input int len, input int vc);
    logic [FLIT_DATA_SIZE-1:0] w;
    flit_t f;
    int nb;
    w = $urandom();
    w[31:28] = 4'd3;
    w[27:24] = 4'd2;
    w[23:21] = 3'd1;
    w[20:13] = 8'(len);
    w[0]     = single;
    mem[wr_n] = w;
    wr_n++;
    nb = (single || len == 0) ? 0 : len;
    f.data = w;
    f.vc_id = VC_ID_W'(vc);
    f.flit_label = (nb == 0) ? HEADTAIL : HEAD;
    exp_q.push_back(f);
    for (int i = 0; i < nb; i++) begin
      w = $urandom();
      mem[wr_n] = w;
      wr_n++;
      f.data = w;
      f.flit_label = (i == nb - 1) ? TAIL : BODY;
      exp_q.push_back(f);
    end
  endtask

  task automatic drain(input int extra);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      step();
      guard++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (extra) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int p0, f1, guard;

    vecs[0] = '{1'b1, 5, 2'b01, 2'b11, 0, 0};
    vecs[1] = '{1'b0, 4, 2'b11, 2'b11, 1, 0};
    vecs[2] = '{1'b0, 2, 2'b11, 2'b11, 0, 0};
    vecs[3] = '{1'b0, 1, 2'b11, 2'b11, 1, 0};
    vecs[4] = '{1'b0, 0, 2'b10, 2'b11, 1, 1};
    vecs[5] = '{1'b0, 3, 2'b11, 2'b01, 0, 0};
    vecs[6] = '{1'b0, 7, 2'b11, 2'b11, 1, 1};

    clear_stats();
    repeat (3) step();
    chk("rst_valid", 64'(bus.router_valid_in), 64'(0));
    chk("rst_ren", 64'(bus.router_rdbuf_ren), 64'(0));
    chk("rst_data", 64'(bus.router_data_in), 64'(0));
    chk("rst_cnt", 64'(bus.pkt_sent_cnt), 64'(0));
    chk("rst_len_err", 64'(bus.len_err), 64'(0));
    rst_n = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 7; v++) begin
      on_off = vecs[v].on_off;
      alloc  = vecs[v].alloc;
      clear_stats();
      push_pkt(vecs[v].single, vecs[v].len, vecs[v].vc);
      nb = (vecs[v].single || vecs[v].len == 0) ? 0 : vecs[v].len;
      drain(3);
      exp_cnt++;
      chk("latency", 64'(first_val - first_ren), 64'(2));
      chk("contiguous", 64'(last_val - first_val), 64'(nflits - 1));
      chk("pops", 64'(pops), 64'(1 + nb));
      chk("len_err_cycles", 64'(err_cycles), 64'(vecs[v].err));
      chk("pkt_cnt", 64'(bus.pkt_sent_cnt), 64'(exp_cnt));
    end

    // back-to-back packets rotate across both VCs
    on_off = 2'b11;
    alloc  = 2'b11;
    clear_stats();
    push_pkt(1'b0, 1, 0);
    push_pkt(1'b0, 1, 1);
    push_pkt(1'b0, 1, 0);
    drain(3);
    exp_cnt += 3;
    chk("b2b_pops", 64'(pops), 64'(6));
    chk("b2b_cnt", 64'(bus.pkt_sent_cnt), 64'(exp_cnt));

    // VC1 switched off for 5 cycles after the 2nd BODY
    clear_stats();
    push_pkt(1'b0, 6, 1);
    guard = 0;
    while (bodies < 2 && guard < 50) begin
      step();
      guard++;
    end
    chk("stall_reach_body2", 64'(bodies), 64'(2));
    on_off = 2'b01;
    p0 = pops;
    step();
    f1 = nflits;
    repeat (4) step();
    chk("stall_no_pop", 64'(pops - p0), 64'(0));
    on_off = 2'b11;
    step();
    chk("stall_one_more_flit", 64'(nflits - f1), 64'(1));
    drain(3);
    exp_cnt++;
    chk("stall_pops", 64'(pops), 64'(7));
    chk("stall_cnt", 64'(bus.pkt_sent_cnt), 64'(exp_cnt));

    // FIFO empty toggling mid-packet
    clear_stats();
    push_pkt(1'b0, 5, 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      hold_empty = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    hold_empty = 1'b0;
    drain(3);
    exp_cnt++;
    chk("bubble_pops", 64'(pops), 64'(6));
    chk("bubble_cnt", 64'(bus.pkt_sent_cnt), 64'(exp_cnt));

    // reset in the middle of a packet
    clear_stats();
    push_pkt(1'b0, 4, 1);
    guard = 0;
    while (bodies < 1 && guard < 50) begin
      step();
      guard++;
    end
    rst_n = 1'b0;
    step();
    step();
    chk("midrst_valid", 64'(bus.router_valid_in), 64'(0));
    chk("midrst_ren", 64'(bus.router_rdbuf_ren), 64'(0));
    chk("midrst_cnt", 64'(bus.pkt_sent_cnt), 64'(0));
    chk("midrst_data", 64'(bus.router_data_in), 64'(0));
    exp_q.delete();
    rst_n = 1'b1;
    exp_cnt = 0;
    step();
    clear_stats();
    push_pkt(1'b1, 0, 0);
    drain(3);
    exp_cnt++;
    chk("postrst_latency", 64'(first_val - first_ren), 64'(2));
    chk("postrst_cnt", 64'(bus.pkt_sent_cnt), 64'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
